// File: rtl/acondicionador_movimiento.sv
// Motion (PIR) input conditioner: synchroniser, debounce, hold stretch,
// lockout and a saturating qualification counter.
module acondicionador_movimiento #(
    parameter int DEBOUNCE  = 16,
    parameter int HOLD      = 1000,
    parameter int LOCKOUT   = 500,
    parameter int RETRIGGER = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pir_in,
    input  logic       clear_count,
    output logic       signD,
    output logic       detect_pulse,
    output logic       busy,
    output logic [7:0] event_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB,
        ST_ACTIVE,
        ST_LOCK
    } state_t;

    localparam logic [15:0] D_LAST = 16'(DEBOUNCE - 1);
    localparam logic [15:0] H_LOAD = 16'(HOLD - 1);
    localparam logic [15:0] L_LOAD = 16'(LOCKOUT - 1);

    state_t      state, state_n;
    logic        s1, s2;
    logic [15:0] dcnt, dcnt_n;
    logic [15:0] tcnt, tcnt_n;
    logic        sign_n;
    logic        qualify;

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        tcnt_n  = tcnt;
        sign_n  = signD;
        qualify = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            dcnt_n  = '0;
            tcnt_n  = '0;
            sign_n  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    sign_n = 1'b0;
                    if (s2) begin
                        if (DEBOUNCE == 1) begin
                            qualify = 1'b1;
                        end else begin
                            state_n = ST_DEB;
                            dcnt_n  = 16'd1;
                        end
                    end
                end
                ST_DEB: begin
                    if (!s2) begin
                        state_n = ST_IDLE;
                        dcnt_n  = '0;
                    end else if (dcnt == D_LAST) begin
                        qualify = 1'b1;
                    end else begin
                        dcnt_n = dcnt + 16'd1;
                    end
                end
                ST_ACTIVE: begin
                    if ((RETRIGGER != 0) && s2) begin
                        tcnt_n = H_LOAD;
                    end else if (tcnt == '0) begin
                        sign_n = 1'b0;
                        if (LOCKOUT == 0) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_LOCK;
                            tcnt_n  = L_LOAD;
                        end
                    end else begin
                        tcnt_n = tcnt - 16'd1;
                    end
                end
                ST_LOCK: begin
                    if (tcnt == '0) begin
                        state_n = ST_IDLE;
                    end else begin
                        tcnt_n = tcnt - 16'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        // Entry into ACTIVE loads the hold timer and raises the level
        if (qualify) begin
            state_n = ST_ACTIVE;
            dcnt_n  = '0;
            tcnt_n  = H_LOAD;
            sign_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            state        <= ST_IDLE;
            dcnt         <= '0;
            tcnt         <= '0;
            signD        <= 1'b0;
            detect_pulse <= 1'b0;
            busy         <= 1'b0;
            event_count  <= '0;
        end else begin
            s1           <= pir_in;
            s2           <= s1;
            state        <= state_n;
            dcnt         <= dcnt_n;
            tcnt         <= tcnt_n;
            signD        <= sign_n;
            detect_pulse <= qualify;
            busy         <= (state_n != ST_IDLE);
            if (clear_count) begin
                event_count <= '0;
            end else if (qualify && (event_count != 8'hFF)) begin
                event_count <= event_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_acondicionador_movimiento.sv
// Directed bench for acondicionador_movimiento; detect_pulse cycles are
// predicted into queues and matched by negedge monitors.
module tb_acondicionador_movimiento;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pir0, pir1;
    logic       clear0, clear1;
    logic       sig0, sig1;
    logic       pulse0, pulse1;
    logic       busy0, busy1;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q0[$];
    int q1[$];

    acondicionador_movimiento #(
        .DEBOUNCE(4), .HOLD(8), .LOCKOUT(5), .RETRIGGER(0)
    ) u0 (
        .clk(clk), .reset(reset), .enable(enable), .pir_in(pir0),
        .clear_count(clear0), .signD(sig0), .detect_pulse(pulse0),
        .busy(busy0), .event_count(cnt0)
    );

    acondicionador_movimiento #(
        .DEBOUNCE(4), .HOLD(8), .LOCKOUT(5), .RETRIGGER(1)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable), .pir_in(pir1),
        .clear_count(clear1), .signD(sig1), .detect_pulse(pulse1),
        .busy(busy1), .event_count(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each pulse must land on the cycle predicted when its stimulus was driven
    always @(negedge clk) begin
        int e;
        if (pulse0) begin
            e = (q0.size() > 0) ? q0.pop_front() : -1;
            chk("pulse0_cycle", cyc, e);
        end
        if (pulse1) begin
            e = (q1.size() > 0) ? q1.pop_front() : -1;
            chk("pulse1_cycle", cyc, e);
        end
    end

    initial begin
        reset = 1'b0; enable = 1'b1;
        pir0 = 1'b0; pir1 = 1'b0;
        clear0 = 1'b0; clear1 = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_sig", sig0, 0);
        chk("rst_pulse", pulse0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_cnt", cnt0, 0);
        #21 reset = 1'b0;
        tick(2);

        // basic detect, hold 8, lockout 5
        pir0 = 1'b1;
        q0.push_back(cyc + 6);
        tick(5);
        chk("t1_sig_pre", sig0, 0);
        tick(1);
        chk("t1_sig_rise", sig0, 1);
        chk("t1_cnt", cnt0, 1);
        tick(7);
        chk("t1_sig_last", sig0, 1);
        tick(1);
        chk("t1_sig_fall", sig0, 0);
        chk("t1_busy_lock", busy0, 1);
        tick(1);
        pir0 = 1'b0;
        tick(3);
        chk("t1_busy_end", busy0, 1);
        tick(1);
        chk("t1_busy_idle", busy0, 0);
        tick(3);

        // glitch rejection: 3 high, 1 low, 3 high
        pir0 = 1'b1; tick(3);
        pir0 = 1'b0; tick(1);
        pir0 = 1'b1; tick(3);
        pir0 = 1'b0; tick(10);
        chk("glitch_sig", sig0, 0);
        chk("glitch_cnt", cnt0, 1);

        // lockout: pulse inside lockout ignored, later one qualifies
        clear0 = 1'b1; tick(1); clear0 = 1'b0;
        chk("clr_cnt", cnt0, 0);
        pir0 = 1'b1;
        q0.push_back(cyc + 6);
        tick(6);
        chk("lk_sig", sig0, 1);
        chk("lk_cnt1", cnt0, 1);
        pir0 = 1'b0;
        tick(6);
        pir0 = 1'b1;
        tick(2);
        chk("lk_fall", sig0, 0);
        chk("lk_busy", busy0, 1);
        tick(3);
        pir0 = 1'b0;
        tick(2);
        chk("lk_idle", busy0, 0);
        tick(1);
        chk("lk_ignored", busy0, 0);
        chk("lk_cnt_hold", cnt0, 1);
        pir0 = 1'b1;
        q0.push_back(cyc + 6);
        tick(6);
        chk("lk_cnt2", cnt0, 2);
        pir0 = 1'b0;
        tick(16);

        // saturation then clear on a qualifying edge
        clear0 = 1'b1; tick(1); clear0 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pir0 = 1'b1;
            q0.push_back(cyc + 6);
            tick(6);
            pir0 = 1'b0;
            tick(14);
            if (i == 254) chk("sat_255", cnt0, 255);
        end
        chk("sat_hold", cnt0, 255);
        pir0 = 1'b1;
        q0.push_back(cyc + 6);
        tick(5);
        chk("clrq_pre", cnt0, 255);
        clear0 = 1'b1;
        tick(1);
        clear0 = 1'b0;
        chk("clrq_cnt", cnt0, 0);
        chk("clrq_sig", sig0, 1);
        pir0 = 1'b0;
        tick(16);

        // retrigger keeps level until 8 cycles after last high sample
        pir1 = 1'b1;
        q1.push_back(cyc + 6);
        tick(6);
        chk("rt_rise", sig1, 1);
        tick(20);
        pir1 = 1'b0;
        tick(9);
        chk("rt_last", sig1, 1);
        tick(1);
        chk("rt_fall", sig1, 0);
        chk("rt_busy", busy1, 1);
        chk("rt_cnt", cnt1, 1);
        tick(8);

        // enable drop mid-debounce
        pir0 = 1'b1;
        tick(3);
        chk("en_deb_busy", busy0, 1);
        enable = 1'b0;
        tick(1);
        chk("en_idle", busy0, 0);
        tick(4);
        pir0 = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(10);
        chk("en_sig", sig0, 0);
        chk("en_cnt", cnt0, 0);

        // asynchronous reset mid-ACTIVE
        pir0 = 1'b1;
        q0.push_back(cyc + 6);
        tick(8);
        chk("ra_sig", sig0, 1);
        chk("ra_cnt", cnt0, 1);
        #1 reset = 1'b1;
        #1;
        chk("ra_sig0", sig0, 0);
        chk("ra_pulse0", pulse0, 0);
        chk("ra_busy0", busy0, 0);
        chk("ra_cnt0", cnt0, 0);
        pir0 = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);
        chk("ra_after_sig", sig0, 0);
        chk("ra_after_busy", busy0, 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
